// File: rtl/pc_gen.sv
// Program-counter generator for instruction fetch: BOOT/RUN/HALT FSM, priority redirect, 1-cycle update latency,
// fetch_addr held while fetch_valid & !fetch_ready. Optional trap entry (trap_valid/trap_vector/epc) under `PC_TRAP_EN.
module pc_gen #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     INSTR_BYTES  = 4,
    parameter int unsigned     BOOT_DELAY   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_addr,
    input  logic            halt_req,
    input  logic            resume_req,
`ifdef PC_TRAP_EN
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] epc,
`endif
    input  logic            fetch_ready,
    output logic            fetch_valid,
    output logic [XLEN-1:0] fetch_addr,
    output logic [XLEN-1:0] next_seq_addr,
    output logic            misaligned_err,
    output logic            halted
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam int unsigned     CW         = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;
    localparam logic [XLEN-1:0] LOW_BITS   = XLEN'(INSTR_BYTES - 1);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~LOW_BITS;
    localparam logic [XLEN-1:0] STEP       = XLEN'(INSTR_BYTES);

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            mis_q, mis_d;
    logic            fire;
    logic            boot_done;

    assign fire          = fetch_valid & fetch_ready;
    assign boot_done     = (32'(cnt_q) + 32'd1) >= BOOT_DELAY;
    assign fetch_valid   = (state_q == ST_RUN) & enable;
    assign fetch_addr    = pc_q;
    assign next_seq_addr = pc_q + STEP;
    assign misaligned_err = mis_q;
    assign halted        = (state_q == ST_HALT);

`ifdef PC_TRAP_EN
    logic [XLEN-1:0] epc_q, epc_d;
    logic            trap_take;

    // Traps during BOOT are dropped; the PC is not yet meaningful.
    assign trap_take = trap_valid & (state_q != ST_BOOT);
    assign epc       = epc_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        mis_d   = 1'b0;
`ifdef PC_TRAP_EN
        epc_d   = epc_q;
`endif
        case (state_q)
            ST_BOOT: begin
                if (boot_done) state_d = ST_RUN;
                else           cnt_d   = cnt_q + CW'(1);
            end
            ST_RUN:  if (halt_req)   state_d = ST_HALT;
            ST_HALT: if (resume_req) state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase

`ifdef PC_TRAP_EN
        if (trap_take) begin
            pc_d    = trap_vector & ALIGN_MASK;
            epc_d   = pc_q;
            state_d = ST_RUN;
        end else
`endif
        // A redirect kills any request accepted this cycle, so it overrides fire.
        if (redirect_valid) begin
            pc_d  = redirect_addr & ALIGN_MASK;
            mis_d = |(redirect_addr & LOW_BITS);
        end else if (fire) begin
            pc_d = pc_q + STEP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            cnt_q   <= '0;
            pc_q    <= RESET_VECTOR;
            mis_q   <= 1'b0;
`ifdef PC_TRAP_EN
            epc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            mis_q   <= mis_d;
`ifdef PC_TRAP_EN
            epc_q   <= epc_d;
`endif
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: default instance plus a wrap/zero-boot-delay instance.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        halt_req;
    logic        resume_req;
    logic        fetch_ready;
    logic        fetch_valid, fetch_valid_b;
    logic [31:0] fetch_addr, fetch_addr_b;
    logic [31:0] next_seq_addr, next_seq_addr_b;
    logic        misaligned_err, misaligned_err_b;
    logic        halted, halted_b;
`ifdef PC_TRAP_EN
    logic        trap_valid;
    logic [31:0] trap_vector;
    logic [31:0] epc, epc_b;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .INSTR_BYTES(4), .BOOT_DELAY(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .halt_req(halt_req), .resume_req(resume_req),
`ifdef PC_TRAP_EN
        .trap_valid(trap_valid), .trap_vector(trap_vector), .epc(epc),
`endif
        .fetch_ready(fetch_ready), .fetch_valid(fetch_valid), .fetch_addr(fetch_addr),
        .next_seq_addr(next_seq_addr), .misaligned_err(misaligned_err), .halted(halted)
    );

    pc_gen #(.XLEN(32), .RESET_VECTOR(32'hFFFF_FFFC), .INSTR_BYTES(4), .BOOT_DELAY(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .halt_req(halt_req), .resume_req(resume_req),
`ifdef PC_TRAP_EN
        .trap_valid(trap_valid), .trap_vector(trap_vector), .epc(epc_b),
`endif
        .fetch_ready(fetch_ready), .fetch_valid(fetch_valid_b), .fetch_addr(fetch_addr_b),
        .next_seq_addr(next_seq_addr_b), .misaligned_err(misaligned_err_b), .halted(halted_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; fetch_ready = 1'b1;
        redirect_valid = 1'b0; redirect_addr = '0;
        halt_req = 1'b0; resume_req = 1'b0;
`ifdef PC_TRAP_EN
        trap_valid = 1'b0; trap_vector = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'b0, fetch_valid}, 32'd0);
        check("rst_addr", fetch_addr, 32'h0);
        check("rst_halted", {31'b0, halted}, 32'd0);
        check("rst_mis", {31'b0, misaligned_err}, 32'd0);
        check("rst_addr_b", fetch_addr_b, 32'hFFFF_FFFC);
        check("rst_nseq_b", next_seq_addr_b, 32'h0);
        rst_n = 1'b1;
        #1;
        check("boot0_valid", {31'b0, fetch_valid}, 32'd0);
        check("boot0_valid_b", {31'b0, fetch_valid_b}, 32'd0);

        step();
        check("boot1_valid", {31'b0, fetch_valid}, 32'd0);
        check("run_valid_b", {31'b0, fetch_valid_b}, 32'd1);
        check("run_addr_b", fetch_addr_b, 32'hFFFF_FFFC);
        step();
        check("run_valid", {31'b0, fetch_valid}, 32'd1);
        check("seq0", fetch_addr, 32'h0);
        check("wrap_b", fetch_addr_b, 32'h0);
        step();
        check("seq4", fetch_addr, 32'h4);
        step();
        check("seq8", fetch_addr, 32'h8);
        check("nseq_c", next_seq_addr, 32'hC);
        step();
        step();
        check("seq10", fetch_addr, 32'h10);

        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold", fetch_addr, 32'h10);
            check("stall_valid", {31'b0, fetch_valid}, 32'd1);
        end
        fetch_ready = 1'b1;
        step();
        check("after_stall", fetch_addr, 32'h14);
        repeat (3) step();
        check("seq20", fetch_addr, 32'h20);

        redirect_valid = 1'b1; redirect_addr = 32'h1002;
        step();
        redirect_valid = 1'b0;
        check("redir_mis_addr", fetch_addr, 32'h1000);
        check("redir_mis_err", {31'b0, misaligned_err}, 32'd1);
        step();
        check("after_redir", fetch_addr, 32'h1004);
        check("mis_pulse_end", {31'b0, misaligned_err}, 32'd0);

        redirect_valid = 1'b1; redirect_addr = 32'h40;
        step();
        redirect_valid = 1'b0;
        check("redir_aligned", fetch_addr, 32'h40);
        check("aligned_no_err", {31'b0, misaligned_err}, 32'd0);

        halt_req = 1'b1; resume_req = 1'b1;
        step();
        halt_req = 1'b0; resume_req = 1'b0;
        check("halt_set", {31'b0, halted}, 32'd1);
        check("halt_addr", fetch_addr, 32'h44);
        check("halt_valid", {31'b0, fetch_valid}, 32'd0);
        step();
        check("halt_hold", fetch_addr, 32'h44);
        check("halt_stay", {31'b0, halted}, 32'd1);
        halt_req = 1'b1; resume_req = 1'b1;
        step();
        halt_req = 1'b0; resume_req = 1'b0;
        check("resume_halted", {31'b0, halted}, 32'd0);
        check("resume_valid", {31'b0, fetch_valid}, 32'd1);
        check("resume_addr", fetch_addr, 32'h44);
        step();
        check("resume_seq", fetch_addr, 32'h48);

        enable = 1'b0;
        #1;
        check("en0_valid", {31'b0, fetch_valid}, 32'd0);
        step();
        check("en0_hold", fetch_addr, 32'h48);
        redirect_valid = 1'b1; redirect_addr = 32'h104;
        step();
        redirect_valid = 1'b0;
        check("en0_redir", fetch_addr, 32'h104);
        enable = 1'b1;
        step();
        check("en1_seq", fetch_addr, 32'h108);

`ifdef PC_TRAP_EN
        redirect_valid = 1'b1; redirect_addr = 32'h30;
        step();
        check("pre_trap", fetch_addr, 32'h30);
        trap_valid = 1'b1; trap_vector = 32'h80; redirect_addr = 32'h200;
        step();
        trap_valid = 1'b0; redirect_valid = 1'b0;
        check("trap_addr", fetch_addr, 32'h80);
        check("trap_epc", epc, 32'h30);
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        check("trap_pre_halt", {31'b0, halted}, 32'd1);
        trap_valid = 1'b1; trap_vector = 32'hC1;
        step();
        trap_valid = 1'b0;
        check("trap_from_halt", {31'b0, halted}, 32'd0);
        check("trap_aligned", fetch_addr, 32'hC0);
`endif

        redirect_valid = 1'b1; redirect_addr = 32'h203;
        step();
        redirect_valid = 1'b0;
        check("late_mis", {31'b0, misaligned_err}, 32'd1);
        check("late_mis_addr", fetch_addr, 32'h200);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_addr", fetch_addr, 32'h0);
        check("midrst_mis", {31'b0, misaligned_err}, 32'd0);
        check("midrst_valid", {31'b0, fetch_valid}, 32'd0);
        check("midrst_addr_b", fetch_addr_b, 32'hFFFF_FFFC);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
